// File: rtl/idct_frame_fifo.sv
// idct_frame_fifo: frame-aware elastic buffer behind the IDCT scaling stage.
// The scaling stage has no flow control, so this block absorbs its output.
// It checks sop/eop framing against fftpts and tags framing errors in-band.
// The consumer sees a valid/ready stream through a first-word-fall-through output register.
module idct_frame_fifo #(
   parameter int wData = 24,
   parameter int AW    = 11,
   parameter int wPts  = 12
) (
   input  logic             clk,
   input  logic             rst_sync,
   input  logic             sink_valid,
   output logic             sink_ready,
   input  logic             sink_sop,
   input  logic             sink_eop,
   input  logic [wData-1:0] sink_real,
   input  logic [wData-1:0] sink_imag,
   input  logic [wPts-1:0]  fftpts_in,
   output logic             source_valid,
   input  logic             source_ready,
   output logic             source_sop,
   output logic             source_eop,
   output logic [wData-1:0] source_real,
   output logic [wData-1:0] source_imag,
   output logic [1:0]       source_error,
   output logic [wPts-1:0]  fftpts_out,
   output logic             drop_flag
);

   localparam int W     = 2*wData + 4;
   localparam int DEPTH = 2**AW;

   typedef enum logic {ST_IDLE, ST_INFRAME} state_t;

   state_t         r_state;
   logic [wPts:0]  r_cnt;
   logic [wPts:0]  r_exp;
   logic           r_drop;
   logic [wPts-1:0] r_fftpts;

   logic [W-1:0]   r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW-1:0]  r_waddr;
   logic [AW:0]    r_count;
   logic           r_wen;
   logic [W-1:0]   r_wdata;
   logic           r_ov;
   logic [W-1:0]   r_odata;

   logic           w_acc;
   logic           w_wr;
   logic           w_rd;
   logic           w_pop;
   logic           w_readable;
   logic [1:0]     w_err;
   logic [wPts:0]  w_cnt_inc;
   logic [wPts:0]  w_fpts_ext;

   // Handshakes, write qualification and per-beat error tag
   always_comb begin
      w_fpts_ext = {1'b0, fftpts_in};
      w_cnt_inc  = r_cnt + (wPts+1)'(1);
      sink_ready = !rst_sync && !r_count[AW];
      w_acc      = sink_valid && sink_ready;
      w_wr       = w_acc && (sink_sop || (r_state == ST_INFRAME));
      w_pop      = r_ov && source_ready;
      // The staged write is counted but not yet readable
      w_readable = (r_count != {{AW{1'b0}}, r_wen});
      w_rd       = w_readable && (!r_ov || source_ready);
      w_err      = '0;
      if (r_state == ST_IDLE) begin
         w_err[1] = sink_eop && (w_fpts_ext != (wPts+1)'(1));
      end else begin
         w_err[0] = sink_sop;
         w_err[1] = sink_eop && (sink_sop || (w_cnt_inc != r_exp));
      end
   end

   // Frame FSM: length counting, fftpts latch and sticky drop flag
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_exp    <= '0;
         r_drop   <= 1'b0;
         r_fftpts <= '0;
      end else if (w_acc) begin
         case (r_state)
            ST_IDLE: begin
               if (sink_sop) begin
                  r_exp    <= w_fpts_ext;
                  r_cnt    <= (wPts+1)'(1);
                  r_fftpts <= fftpts_in;
                  r_state  <= sink_eop ? ST_IDLE : ST_INFRAME;
               end else begin
                  r_drop <= 1'b1;
               end
            end
            ST_INFRAME: begin
               if (sink_sop) begin
                  r_exp    <= w_fpts_ext;
                  r_cnt    <= (wPts+1)'(1);
                  r_fftpts <= fftpts_in;
                  r_state  <= sink_eop ? ST_IDLE : ST_INFRAME;
               end else if (sink_eop) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write staging, pointers and occupancy; a beat is counted when accepted, committed a cycle later
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wen <= w_wr;
         if (w_wr) begin
            r_waddr <= r_wptr;
            r_wdata <= {w_err, sink_sop, sink_eop, sink_real, sink_imag};
            r_wptr  <= r_wptr + 1'b1;
         end
         if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // RAM write port
   always_ff @(posedge clk) begin
      if (r_wen) begin
         r_mem[r_waddr] <= r_wdata;
      end
   end

   // Output register: reloads from RAM on pop or when empty, holds while stalled
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         r_ov    <= 1'b0;
         r_odata <= '0;
      end else if (w_rd) begin
         r_ov    <= 1'b1;
         r_odata <= r_mem[r_rptr];
      end else if (w_pop) begin
         r_ov <= 1'b0;
      end
   end

   assign source_valid = r_ov;
   assign {source_error, source_sop, source_eop, source_real, source_imag} = r_odata;
   assign fftpts_out   = r_fftpts;
   assign drop_flag    = r_drop;

endmodule
